// File: rtl/uart_apb_scheduler_pkg.sv
// rtl/uart_apb_scheduler_pkg.sv - shared constants and FSM states for the UART APB scheduler
package uart_sched_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  typedef enum logic [2:0] {
    ST_CFG1,
    ST_CFG2,
    ST_POLL,
    ST_RXRD,
    ST_TXWR
  } state_t;

endpackage

// File: rtl/uart_apb_scheduler_if.sv
// rtl/uart_apb_scheduler_if.sv - APB bus between the scheduler and the UART register slave
interface uart_apb_scheduler_if;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_sched_apb_xfer.sv
// rtl/uart_sched_apb_xfer.sv - single-transfer APB engine; done/rdata/slverr are valid in the PREADY cycle
module uart_sched_apb_xfer (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        i_start,
  input  logic                        i_write,
  input  logic [4:0]                  i_addr,
  input  logic [7:0]                  i_wdata,
  output logic                        o_done,
  output logic [7:0]                  o_rdata,
  output logic                        o_slverr,
  uart_apb_scheduler_if.master        apb
);

  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic [4:0] r_paddr;
  logic [7:0] r_pwdata;

  // start is only honoured while idle; address and data are frozen for the whole transfer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 5'h00;
      r_pwdata  <= 8'h00;
    end else if (!r_psel) begin
      if (i_start) begin
        r_psel   <= 1'b1;
        r_pwrite <= i_write;
        r_paddr  <= i_addr;
        r_pwdata <= i_wdata;
      end
    end else if (!r_penable) begin
      r_penable <= 1'b1;
    end else if (apb.PREADY) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PADDR   = r_paddr;
  assign apb.PWDATA  = r_pwdata;

  assign o_done   = r_psel & r_penable & apb.PREADY;
  assign o_rdata  = apb.PRDATA;
  assign o_slverr = o_done & apb.PSLVERR;

endmodule

// File: rtl/uart_apb_scheduler.sv
// rtl/uart_apb_scheduler.sv - configures the UART, then polls STATUS to drain RX and round-robin TX requesters
module uart_apb_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter bit          PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'b00,
  parameter bit          RX_POLL_EN = 1'b1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  uart_apb_scheduler_if.master   apb,
  input  logic [NUM_REQ-1:0]     tx_req,
  input  logic [8*NUM_REQ-1:0]   tx_data,
  output logic [NUM_REQ-1:0]     tx_ack,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic [2:0]             err_flags,
  input  logic                   err_clr,
  output logic                   cfg_done,
  output logic                   apb_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  state_t               w_next;
  logic                 r_busy;
  logic [PW-1:0]        r_rr;
  logic [PW-1:0]        r_grant;
  logic [7:0]           r_tx_byte;
  logic [NUM_REQ-1:0]   r_tx_ack;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;
  logic [2:0]           r_err;
  logic                 r_cfg_done;
  logic                 r_apb_err;

  logic                 w_start;
  logic                 w_write;
  logic [4:0]           w_addr;
  logic [7:0]           w_wdata;
  logic                 w_done;
  logic [7:0]           w_rdata;
  logic                 w_slverr;
  logic [PW-1:0]        w_grant;
  logic [7:0]           w_sel_byte;
  logic [2:0]           w_new_err;

  assign w_start = ~r_busy;

  uart_sched_apb_xfer u_xfer (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .i_start  (w_start),
    .i_write  (w_write),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_done   (w_done),
    .o_rdata  (w_rdata),
    .o_slverr (w_slverr),
    .apb      (apb)
  );

  // Downward scan so the last hit is the first set request at or above r_rr.
  always_comb begin : p_grant
    int w_idx;
    w_grant    = r_rr;
    w_sel_byte = tx_data[7:0];
    w_idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (tx_req[PW'(w_idx)]) w_grant = PW'(w_idx);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == PW'(i)) w_sel_byte = tx_data[8*i +: 8];
    end
  end

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    w_addr  = ADDR_STATUS;
    w_wdata = 8'h00;
    case (r_state)
      ST_CFG1: begin
        w_write = 1'b1;
        w_addr  = ADDR_CTRL1;
        w_wdata = BAUD_VALUE[7:0];
        if (w_done) w_next = ST_CFG2;
      end
      ST_CFG2: begin
        w_write = 1'b1;
        w_addr  = ADDR_CTRL2;
        w_wdata = {BAUD_VALUE[12:8], PRG_PARITY, PRG_BIT8};
        if (w_done) w_next = ST_POLL;
      end
      ST_POLL: begin
        if (w_done) begin
          if (RX_POLL_EN && w_rdata[STAT_RXRDY])        w_next = ST_RXRD;
          else if (w_rdata[STAT_TXRDY] && (|tx_req))    w_next = ST_TXWR;
        end
      end
      ST_RXRD: begin
        w_addr = ADDR_RXDATA;
        if (w_done) w_next = ST_POLL;
      end
      ST_TXWR: begin
        w_write = 1'b1;
        w_addr  = ADDR_TXDATA;
        w_wdata = r_tx_byte;
        if (w_done) w_next = ST_POLL;
      end
      default: w_next = ST_CFG1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= ST_CFG1;
    else        r_state <= w_next;
  end

  // Clear and fresh error bits on the same edge: fresh bits survive the clear.
  assign w_new_err = (r_state == ST_POLL && w_done) ? w_rdata[STAT_FRAMING:STAT_PARITY] : 3'b000;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_busy     <= 1'b0;
      r_rr       <= '0;
      r_grant    <= '0;
      r_tx_byte  <= 8'h00;
      r_tx_ack   <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_err      <= 3'b000;
      r_cfg_done <= 1'b0;
      r_apb_err  <= 1'b0;
    end else begin
      r_tx_ack   <= '0;
      r_rx_valid <= 1'b0;
      r_apb_err  <= w_slverr;
      r_err      <= (err_clr ? 3'b000 : r_err) | w_new_err;
      if (w_start)     r_busy <= 1'b1;
      else if (w_done) r_busy <= 1'b0;
      if (r_state == ST_POLL && w_next == ST_TXWR) begin
        r_grant   <= w_grant;
        r_tx_byte <= w_sel_byte;
      end
      if (r_state == ST_TXWR && w_done) begin
        r_tx_ack[r_grant] <= 1'b1;
        r_rr <= (r_grant == PW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
      if (r_state == ST_RXRD && w_done && !w_slverr) begin
        r_rx_data  <= w_rdata;
        r_rx_valid <= 1'b1;
      end
      if (r_state == ST_CFG2 && w_done) r_cfg_done <= 1'b1;
    end
  end

  assign tx_ack    = r_tx_ack;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign err_flags = r_err;
  assign cfg_done  = r_cfg_done;
  assign apb_err   = r_apb_err;

endmodule

// File: tb/tb_uart_apb_scheduler.sv
// tb/tb_uart_apb_scheduler.sv - directed bench acting as the UART APB slave
module tb_uart_apb_scheduler;

  logic        clk = 1'b0;
  logic        PRESET;
  logic [3:0]  tx_req;
  logic [31:0] tx_data;
  logic [3:0]  tx_ack;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  err_flags;
  logic        err_clr;
  logic        cfg_done;
  logic        apb_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  uart_apb_scheduler_if apb_if ();

  uart_apb_scheduler #(
    .NUM_REQ    (4),
    .BAUD_VALUE (13'h123),
    .PRG_BIT8   (1'b1),
    .PRG_PARITY (2'b01),
    .RX_POLL_EN (1'b1)
  ) dut (
    .PCLK      (clk),
    .PRESET    (PRESET),
    .apb       (apb_if),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .err_flags (err_flags),
    .err_clr   (err_clr),
    .cfg_done  (cfg_done),
    .apb_err   (apb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serves one transfer: PREADY low for 'waits' access cycles, then high; returns in the cycle after completion.
  task automatic serve(input string tag, input logic [4:0] a, input logic w, input logic [7:0] wd,
                       input logic [7:0] rd, input int waits, input logic err, input logic clr);
    int n = 0;
    while (!(apb_if.PSEL && !apb_if.PENABLE) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_setup"}, 32'(n < 40), 32'd1);
    chk({tag, "_addr"}, 32'(apb_if.PADDR), 32'(a));
    chk({tag, "_dir"}, 32'(apb_if.PWRITE), 32'(w));
    if (w) chk({tag, "_wdata"}, 32'(apb_if.PWDATA), 32'(wd));
    apb_if.PREADY  = 1'b0;
    apb_if.PRDATA  = rd;
    apb_if.PSLVERR = err;
    @(negedge clk);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_penable"}, 32'(apb_if.PENABLE), 32'd1);
      chk({tag, "_addr_hold"}, 32'(apb_if.PADDR), 32'(a));
      if (w) chk({tag, "_wdata_hold"}, 32'(apb_if.PWDATA), 32'(wd));
      chk({tag, "_no_early_pulse"}, 32'({tx_ack, rx_valid}), 32'd0);
      if (i == waits) begin
        apb_if.PREADY = 1'b1;
        err_clr       = clr;
      end
      @(negedge clk);
    end
    apb_if.PREADY  = 1'b0;
    apb_if.PSLVERR = 1'b0;
    err_clr        = 1'b0;
    chk({tag, "_release"}, 32'(apb_if.PSEL), 32'd0);
  endtask

  logic [7:0] exp_byte [4] = '{8'h10, 8'h21, 8'h43, 8'h10};
  logic [3:0] exp_ack  [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    tx_req = 4'b0000;
    tx_data = {8'h43, 8'h32, 8'h21, 8'h10};
    err_clr = 1'b0;
    apb_if.PREADY  = 1'b1;
    apb_if.PRDATA  = 8'h00;
    apb_if.PSLVERR = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apb_if.PSEL), 32'd0);
    chk("rst_penable", 32'(apb_if.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(apb_if.PWRITE), 32'd0);
    chk("rst_paddr", 32'(apb_if.PADDR), 32'd0);
    chk("rst_pwdata", 32'(apb_if.PWDATA), 32'd0);
    chk("rst_outs", 32'({tx_ack, rx_data, rx_valid, err_flags, cfg_done, apb_err}), 32'd0);

    PRESET = 1'b0;
    t0 = cyc;
    serve("cfg1", 5'h08, 1'b1, 8'h23, 8'h00, 0, 1'b0, 1'b0);
    chk("cfg_done_early", 32'(cfg_done), 32'd0);
    serve("cfg2", 5'h0C, 1'b1, 8'h0B, 8'h00, 0, 1'b0, 1'b0);
    chk("cfg_done", 32'(cfg_done), 32'd1);
    chk("cfg_latency", 32'(cyc - t0), 32'd6);

    tx_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      serve("poll_tx", 5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0);
      serve("txwr", 5'h00, 1'b1, exp_byte[k], 8'h00, 0, 1'b0, 1'b0);
      chk("tx_ack", 32'(tx_ack), 32'(exp_ack[k]));
      chk("apb_err_quiet", 32'(apb_err), 32'd0);
      @(negedge clk);
      chk("tx_ack_pulse", 32'(tx_ack), 32'd0);
    end

    tx_req = 4'b0100;
    serve("poll_rxtx", 5'h10, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b0);
    serve("rxrd", 5'h04, 1'b0, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'hA5);
    chk("rx_no_ack", 32'(tx_ack), 32'd0);
    @(negedge clk);
    chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
    serve("poll_after_rx", 5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0);
    serve("txwr_req2", 5'h00, 1'b1, 8'h32, 8'h00, 0, 1'b0, 1'b0);
    chk("tx_ack_req2", 32'(tx_ack), 32'b0100);
    @(negedge clk);

    tx_req = 4'b0001;
    tx_data[7:0] = 8'h5A;
    serve("poll_wait", 5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0);
    serve("txwr_wait", 5'h00, 1'b1, 8'h5A, 8'h00, 3, 1'b0, 1'b0);
    chk("tx_ack_wait", 32'(tx_ack), 32'b0001);
    @(negedge clk);
    tx_req = 4'b0000;

    serve("poll_err1", 5'h10, 1'b0, 8'h00, 8'h11, 0, 1'b0, 1'b0);
    chk("err_framing", 32'(err_flags), 32'b100);
    serve("poll_err2", 5'h10, 1'b0, 8'h00, 8'h09, 0, 1'b0, 1'b1);
    chk("err_clr_new", 32'(err_flags), 32'b010);
    serve("poll_clr", 5'h10, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    chk("err_cleared", 32'(err_flags), 32'b000);

    serve("poll_rxerr", 5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0);
    serve("rxrd_err", 5'h04, 1'b0, 8'h00, 8'h77, 0, 1'b1, 1'b0);
    chk("apb_err", 32'(apb_err), 32'd1);
    chk("rx_valid_on_err", 32'(rx_valid), 32'd0);
    chk("rx_data_kept", 32'(rx_data), 32'hA5);
    @(negedge clk);
    chk("apb_err_pulse", 32'(apb_err), 32'd0);

    PRESET = 1'b1;
    @(negedge clk);
    chk("rst2_psel", 32'(apb_if.PSEL), 32'd0);
    chk("rst2_cfg_done", 32'(cfg_done), 32'd0);
    PRESET = 1'b0;
    serve("cfg1_b", 5'h08, 1'b1, 8'h23, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cfg2_b_setup", 32'({apb_if.PSEL, apb_if.PENABLE}), 32'b10);
    chk("cfg2_b_addr", 32'(apb_if.PADDR), 32'h0C);
    @(negedge clk);
    chk("cfg2_b_access", 32'(apb_if.PENABLE), 32'd1);
    PRESET = 1'b1;
    apb_if.PREADY = 1'b1;
    @(negedge clk);
    chk("midrst_psel", 32'({apb_if.PSEL, apb_if.PENABLE}), 32'd0);
    chk("midrst_cfg_done", 32'(cfg_done), 32'd0);
    apb_if.PREADY = 1'b0;
    PRESET = 1'b0;
    serve("cfg1_again", 5'h08, 1'b1, 8'h23, 8'h00, 0, 1'b0, 1'b0);
    chk("cfg_done_again_early", 32'(cfg_done), 32'd0);
    serve("cfg2_again", 5'h0C, 1'b1, 8'h0B, 8'h00, 0, 1'b0, 1'b0);
    chk("cfg_done_again", 32'(cfg_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
